// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
package iter_divider_pkg;

    // Default datapath geometry; the counter must be able to count to DIV_WIDTH-1.
    localparam int DIV_WIDTH   = 32;
    localparam int DIV_CNT_W   = 6;

    // Cycles from the accepting edge to the done pulse: WIDTH steps plus the sign fix.
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    // Controller states: load in IDLE, one restoring step per CALC cycle, sign fix in FIX.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Two's-complement magnitude of an operand when it is treated as signed.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic neg,
                                                     input logic [DIV_WIDTH-1:0] v);
        return neg ? (~v + DIV_WIDTH'(1)) : v;
    endfunction

endpackage : iter_divider_pkg

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
module iter_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic           ge;

    // The compare runs one bit wider so the bit shifted out of r is not lost;
    // when it fits, the difference is below d and so fits back into WIDTH bits.
    always_comb begin
        shifted = {r_in, q_in[WIDTH-1]};
        ge      = (shifted >= {1'b0, d});
        r_out   = ge ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], ge};
    end

endmodule : iter_divider_div_step

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU unit: quotient to LO, remainder to HI, abortable.
// Handshake: start is taken only in IDLE with abort low; busy is high from the
// next cycle through the done cycle; done is a one-cycle pulse during which
// quot/rem/div_zero carry the new result, and they hold it until the next done.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;        // partial remainder
    logic [WIDTH-1:0] q_q, q_d;        // dividend bits shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;        // divisor magnitude
    logic [WIDTH-1:0] a_raw_q, a_raw_d;// untouched dividend, returned on divide by zero
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;      // in-flight op has a zero divisor
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] step_r, step_q;
    logic [WIDTH-1:0] fix_quot, fix_rem;
    logic             a_neg, b_neg;

    iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d     (d_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    // Final result with signs applied; a zero divisor bypasses the sign fix.
    always_comb begin
        a_neg    = sign & dividend[WIDTH-1];
        b_neg    = sign & divisor[WIDTH-1];
        fix_quot = dz_q ? '1      : (qneg_q ? (~q_q + WIDTH'(1)) : q_q);
        fix_rem  = dz_q ? a_raw_q : (rneg_q ? (~r_q + WIDTH'(1)) : r_q);
    end

    // Next-state logic: operand load, iteration, sign fix and abort override.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        a_raw_d    = a_raw_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    q_d     = a_neg ? (~dividend + WIDTH'(1)) : dividend;
                    d_d     = b_neg ? (~divisor + WIDTH'(1)) : divisor;
                    a_raw_d = dividend;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = (divisor == '0);
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                done       = 1'b1;
                quot_d     = fix_quot;
                rem_d      = fix_rem;
                div_zero_d = dz_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort cancels the owning instruction: no done, prior results kept.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            done       = 1'b0;
            quot_d     = quot_q;
            rem_d      = rem_q;
            div_zero_d = div_zero_q;
        end
    end

    // Outputs show the fresh result during the done cycle, the held one otherwise.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        quot     = done ? fix_quot : quot_q;
        rem      = done ? fix_rem  : rem_q;
        div_zero = done ? dz_q     : div_zero_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            a_raw_q    <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            a_raw_q    <= a_raw_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule : iter_divider
